// File: rtl/sv_common_pkg.sv
// Shared types for pipeline register slices: the skid buffer state encoding.
// The encoding doubles as the occupancy count reported on the level port.
package sv_common_pkg;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_BUSY  = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/dff_async_rst_en.sv
// Enabled payload register with asynchronous active-low clear.
// Used for both the main (output) and skid (overflow) storage of the skid buffer.
module dff_async_rst_en #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_o <= '0;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/skid_buffer_async_rst.sv
// Two-entry valid/ready register slice: data, valid and ready are all flop-driven,
// so downstream back-pressure never reaches the producer combinationally.
module skid_buffer_async_rst
    import sv_common_pkg::*;
#(
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DWIDTH-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DWIDTH-1:0] m_data,
    output logic [1:0]        level
);

    skid_state_e       state_q;
    skid_state_e       state_d;
    logic              s_ready_q;
    logic              s_ready_d;
    logic              s_fire;
    logic              m_fire;
    logic              main_en;
    logic              main_from_skid;
    logic              skid_en;
    logic [DWIDTH-1:0] main_d;
    logic [DWIDTH-1:0] skid_q;

    assign s_fire = s_valid & s_ready_q;
    assign m_fire = m_valid & m_ready;

    always_comb begin
        state_d        = state_q;
        main_en        = 1'b0;
        main_from_skid = 1'b0;
        skid_en        = 1'b0;
        case (state_q)
            SKID_EMPTY: begin
                if (s_fire) begin
                    main_en = 1'b1;
                    state_d = SKID_BUSY;
                end
            end
            SKID_BUSY: begin
                if (s_fire && m_fire) begin
                    main_en = 1'b1;
                end else if (s_fire) begin
                    skid_en = 1'b1;
                    state_d = SKID_FULL;
                end else if (m_fire) begin
                    state_d = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                if (m_fire) begin
                    main_en        = 1'b1;
                    main_from_skid = 1'b1;
                    state_d        = SKID_BUSY;
                end
            end
            default: begin
                state_d = SKID_EMPTY;
            end
        endcase
    end

    // Ready is registered from the next state, so it drops in the same edge that fills the skid slot.
    assign s_ready_d = (state_d != SKID_FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= SKID_EMPTY;
            s_ready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_ready_q <= s_ready_d;
        end
    end

    assign main_d = main_from_skid ? skid_q : s_data;

    dff_async_rst_en #(.W(DWIDTH)) u_main_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (main_en),
        .d_i   (main_d),
        .q_o   (m_data)
    );

    dff_async_rst_en #(.W(DWIDTH)) u_skid_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (skid_en),
        .d_i   (s_data),
        .q_o   (skid_q)
    );

    assign s_ready = s_ready_q;
    assign m_valid = (state_q == SKID_BUSY) || (state_q == SKID_FULL);
    assign level   = state_q;

endmodule

// File: tb/tb_skid_buffer_async_rst.sv
// Directed and randomised checks of the skid buffer: reset, streaming, stall/drain, scoreboard, reset while full.
module tb_skid_buffer_async_rst;

    localparam int DW = 8;

    logic          clk;
    logic          rst_n;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [1:0]    level;

    int total;
    int bad;

    skid_buffer_async_rst #(.DWIDTH(DW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .level   (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        tick();
        tick();
        total++;
        if (m_valid !== 1'b0 || s_ready !== 1'b0 || m_data !== 8'h00 || level !== 2'd0) begin
            bad++;
            $display("FAIL reset_state got v=%b r=%b d=%h l=%0d exp v=0 r=0 d=00 l=0", m_valid, s_ready, m_data, level);
        end
        s_valid = 1'b1;
        s_data  = 8'h77;
        tick();
        rst_n = 1'b1;
        #1;
        total++;
        if (s_ready !== 1'b0 || m_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release_before_edge got r=%b v=%b exp r=0 v=0", s_ready, m_valid);
        end
        s_valid = 1'b0;
        tick();
        total++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0 || level !== 2'd0) begin
            bad++;
            $display("FAIL reset_first_edge got r=%b v=%b l=%0d exp r=1 v=0 l=0", s_ready, m_valid, level);
        end
        // Asynchronous assertion mid-cycle while holding a beat
        s_valid = 1'b1;
        s_data  = 8'h5A;
        tick();
        s_valid = 1'b0;
        total++;
        if (m_valid !== 1'b1 || m_data !== 8'h5A) begin
            bad++;
            $display("FAIL reset_preload got v=%b d=%h exp v=1 d=5a", m_valid, m_data);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (m_valid !== 1'b0 || s_ready !== 1'b0 || m_data !== 8'h00 || level !== 2'd0) begin
            bad++;
            $display("FAIL reset_async got v=%b r=%b d=%h l=%0d exp v=0 r=0 d=00 l=0", m_valid, s_ready, m_data, level);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_streaming();
        m_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(i);
            tick();
            total++;
            if (m_valid !== 1'b1 || m_data !== 8'(i) || s_ready !== 1'b1 || level !== 2'd1) begin
                bad++;
                $display("FAIL stream_beat%0d got v=%b d=%h r=%b l=%0d exp v=1 d=%h r=1 l=1", i, m_valid, m_data, s_ready, level, 8'(i));
            end
        end
        s_valid = 1'b0;
        tick();
        total++;
        if (m_valid !== 1'b0 || level !== 2'd0) begin
            bad++;
            $display("FAIL stream_empty got v=%b l=%0d exp v=0 l=0", m_valid, level);
        end
    endtask

    task automatic test_stall_fill();
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'hA1;
        tick();
        total++;
        if (level !== 2'd1 || m_data !== 8'hA1 || s_ready !== 1'b1) begin
            bad++;
            $display("FAIL stall_first got l=%0d d=%h r=%b exp l=1 d=a1 r=1", level, m_data, s_ready);
        end
        s_data = 8'hA2;
        tick();
        total++;
        if (level !== 2'd2 || m_data !== 8'hA1 || s_ready !== 1'b0 || m_valid !== 1'b1) begin
            bad++;
            $display("FAIL stall_full got l=%0d d=%h r=%b v=%b exp l=2 d=a1 r=0 v=1", level, m_data, s_ready, m_valid);
        end
        s_data = 8'hA3;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (level !== 2'd2 || m_data !== 8'hA1 || s_ready !== 1'b0 || m_valid !== 1'b1) begin
                bad++;
                $display("FAIL stall_hold%0d got l=%0d d=%h r=%b v=%b exp l=2 d=a1 r=0 v=1", i, level, m_data, s_ready, m_valid);
            end
        end
    endtask

    task automatic test_drain();
        m_ready = 1'b1;
        #1;
        total++;
        if (m_data !== 8'hA1 || m_valid !== 1'b1) begin
            bad++;
            $display("FAIL drain_a1 got d=%h v=%b exp d=a1 v=1", m_data, m_valid);
        end
        tick();
        total++;
        if (m_data !== 8'hA2 || m_valid !== 1'b1 || s_ready !== 1'b1 || level !== 2'd1) begin
            bad++;
            $display("FAIL drain_a2 got d=%h v=%b r=%b l=%0d exp d=a2 v=1 r=1 l=1", m_data, m_valid, s_ready, level);
        end
        tick();
        total++;
        if (m_data !== 8'hA3 || m_valid !== 1'b1 || level !== 2'd1) begin
            bad++;
            $display("FAIL drain_a3 got d=%h v=%b l=%0d exp d=a3 v=1 l=1", m_data, m_valid, level);
        end
        s_valid = 1'b0;
        tick();
        total++;
        if (m_valid !== 1'b0 || level !== 2'd0 || s_ready !== 1'b1) begin
            bad++;
            $display("FAIL drain_empty got v=%b l=%0d r=%b exp v=0 l=0 r=1", m_valid, level, s_ready);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] q[$];
        logic [DW-1:0] exp_d;
        logic          sf;
        logic          mf;
        int            guard;
        for (int c = 0; c < 3000; c++) begin
            s_valid = 1'($urandom_range(0, 1));
            m_ready = ($urandom_range(0, 3) != 0);
            s_data  = DW'($urandom_range(0, 255));
            #1;
            sf = s_valid && s_ready;
            mf = m_valid && m_ready;
            if (mf) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rand_spurious cycle=%0d got d=%h exp no beat", c, m_data);
                end else begin
                    exp_d = q.pop_front();
                    total++;
                    if (m_data !== exp_d) begin
                        bad++;
                        $display("FAIL rand_data cycle=%0d got d=%h exp d=%h", c, m_data, exp_d);
                    end
                end
            end
            if (sf) q.push_back(s_data);
            tick();
            total++;
            if (level !== 2'(q.size()) || m_valid !== (q.size() != 0) || (s_ready && level == 2'd2)) begin
                bad++;
                $display("FAIL rand_occupancy cycle=%0d got l=%0d v=%b r=%b exp l=%0d", c, level, m_valid, s_ready, q.size());
            end
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        guard   = 0;
        while (q.size() != 0 && guard < 10) begin
            #1;
            if (m_valid) begin
                exp_d = q.pop_front();
                total++;
                if (m_data !== exp_d) begin
                    bad++;
                    $display("FAIL rand_drain got d=%h exp d=%h", m_data, exp_d);
                end
            end
            tick();
            guard++;
        end
        total++;
        if (q.size() != 0 || m_valid !== 1'b0) begin
            bad++;
            $display("FAIL rand_drain_timeout got left=%0d v=%b exp left=0 v=0", q.size(), m_valid);
        end
    endtask

    task automatic test_reset_full();
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'hA1;
        tick();
        s_data = 8'hA2;
        tick();
        s_valid = 1'b0;
        total++;
        if (level !== 2'd2) begin
            bad++;
            $display("FAIL rstfull_fill got l=%0d exp l=2", level);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (level !== 2'd0 || m_valid !== 1'b0 || s_ready !== 1'b0 || m_data !== 8'h00) begin
            bad++;
            $display("FAIL rstfull_async got l=%0d v=%b r=%b d=%h exp l=0 v=0 r=0 d=00", level, m_valid, s_ready, m_data);
        end
        tick();
        rst_n   = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (m_valid !== 1'b0 || level !== 2'd0) begin
                bad++;
                $display("FAIL rstfull_stale%0d got v=%b d=%h l=%0d exp v=0 l=0", i, m_valid, m_data, level);
            end
        end
        s_valid = 1'b1;
        s_data  = 8'h55;
        tick();
        s_valid = 1'b0;
        total++;
        if (m_valid !== 1'b1 || m_data !== 8'h55 || level !== 2'd1) begin
            bad++;
            $display("FAIL rstfull_fresh got v=%b d=%h l=%0d exp v=1 d=55 l=1", m_valid, m_data, level);
        end
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_streaming();
        test_stall_fill();
        test_drain();
        test_random();
        test_reset_full();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
